// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM states, access sizes and lane helpers.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Access size implied by the opcode; anything unrecognised is treated as a word.
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
            default:              op_size = SZ_W;
        endcase
    endfunction

    // True when the low address bits break the natural alignment of the access.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
        case (sz)
            SZ_H:    is_misaligned = lane[0];
            SZ_W:    is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Store byte enables for a given size and byte lane.
    function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] lane);
        case (sz)
            SZ_B:    store_be = 4'b0001 << lane;
            SZ_H:    store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'hF;
        endcase
    endfunction

    // Store data replicated across every lane so the enables alone pick the target bytes.
    function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] data);
        case (sz)
            SZ_B:    store_wdata = {4{data[7:0]}};
            SZ_H:    store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and sign/zero extension of the returned memory word.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [5:0]  opcode,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to the load flavour.
    always_comb begin
        shifted   = rdata >> {lane, 3'b000};
        byte_sel  = shifted[7:0];
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (opcode)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack access, upstream stall, MEM forwarding taps and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses are rejected with bus_err1_WB
// instead of being truncated to their natural boundary.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_PR,
    input  logic [31:0] aluResult1_PR,
    input  logic [31:0] readDataB1_PR,
    input  logic [4:0]  writeRegister1_PR,
    input  logic        do_writeback1_PR,
    input  logic        MemRead1_PR,
    input  logic        MemWrite1_PR,
    input  logic        MemtoReg1_PR,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEM,
    output logic [31:0] Data1_MEM,
    output logic [4:0]  writeRegister1_MEM,
    output logic        do_writeback1_MEM,
    output logic [31:0] Data1_WB,
    output logic [4:0]  writeRegister1_WB,
    output logic        do_writeback1_WB,
    output logic        bus_err1_WB
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       opcode;
    logic [1:0]       lane;
    size_t            sz;
    logic             mem_op;
    logic             misaligned;
    logic             timeout;
    logic             done;
    logic             err_timeout;
    logic [31:0]      load_data;
    logic             unused_instr;

    assign opcode       = Instr1_PR[31:26];
    assign unused_instr = ^Instr1_PR[25:0];
    assign lane         = aluResult1_PR[1:0];
    assign sz           = op_size(opcode);
    assign mem_op       = MemRead1_PR | MemWrite1_PR;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & is_misaligned(sz, lane);
`else
    assign misaligned = 1'b0;
`endif

    // Access completion: ack wins over a simultaneous timeout.
    assign timeout     = (state == ACCESS) && (cnt == CNT_LAST);
    assign done        = (state == ACCESS) && (dmem_ack || timeout);
    assign err_timeout = timeout && !dmem_ack;
    assign stall_MEM   = mem_op && !misaligned && !done;

    // MEM-level forwarding taps; load results are not yet available here.
    assign Data1_MEM          = aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & ~MemtoReg1_PR;

    mem_load_align u_load_align (
        .rdata     (dmem_rdata),
        .lane      (lane),
        .opcode    (opcode),
        .load_data (load_data)
    );

    // Access FSM with registered bus outputs held steady for the whole access.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        state      <= ACCESS;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite1_PR;
                        dmem_addr  <= {aluResult1_PR[31:2], 2'b00};
                        dmem_wdata <= store_wdata(sz, readDataB1_PR);
                        dmem_be    <= MemWrite1_PR ? store_be(sz, lane) : 4'hF;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, error marker on timeout or rejected access.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Data1_WB          <= '0;
            writeRegister1_WB <= '0;
            do_writeback1_WB  <= 1'b0;
            bus_err1_WB       <= 1'b0;
        end else if (stall_MEM) begin
            Data1_WB          <= '0;
            writeRegister1_WB <= '0;
            do_writeback1_WB  <= 1'b0;
            bus_err1_WB       <= 1'b0;
        end else if (mem_op && (misaligned || err_timeout)) begin
            Data1_WB          <= aluResult1_PR;
            writeRegister1_WB <= writeRegister1_PR;
            do_writeback1_WB  <= 1'b0;
            bus_err1_WB       <= 1'b1;
        end else begin
            Data1_WB          <= MemtoReg1_PR ? load_data : aluResult1_PR;
            writeRegister1_WB <= writeRegister1_PR;
            do_writeback1_WB  <= do_writeback1_PR;
            bus_err1_WB       <= 1'b0;
        end
    end

endmodule
